// File: rtl/fp_add_pipe_if.sv
// Operand/result stream bundle for fp_add_pipe.
// The slave modport is the adder side; the master modport is the dispatch/writeback side.
interface fp_add_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [1:0]       in_rm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  modport master (
    output in_valid, in_a, in_b, in_rm, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_rm, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_flags
  );
endinterface

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE 754 adder: S1 unpack/classify/align, S2 add/sub, S3 normalise/round/pack.
// Operands carry rounding mode and tag down the pipe; S3 registers drive the result stream.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  fp_add_pipe_if.slave  bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int AW = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int SW = MAN_W + 5;  // AW plus carry-out
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [1:0] RM_RNE = 2'b00, RM_RTZ = 2'b01, RM_RDN = 2'b10, RM_RUP = 2'b11;

  logic v1, v2, v3, adv1, adv2, adv3;
  assign adv3 = !v3 || bus.out_ready;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;
  assign bus.in_ready = adv1;

  // S1 combinational: unpack, classify, order by magnitude, align smaller operand
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, xa, xb;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   ma, mb, m_s;
  logic             nan_a, nan_b, inf_a, inf_b, a_big;
  logic             c_spec, c_inv, c_sign;
  logic [W-1:0]     c_spec_res;
  logic [EXP_W-1:0] c_exp, c_diff;
  logic [AW-1:0]    c_ml, c_ms, ext_s, sh_s, mask_s;

  assign {sa, ea, fa} = bus.in_a;
  assign {sb, eb, fb} = bus.in_b;

  always_comb begin
    nan_a  = (ea == EXP_MAX) && (fa != '0);
    nan_b  = (eb == EXP_MAX) && (fb != '0);
    inf_a  = (ea == EXP_MAX) && (fa == '0);
    inf_b  = (eb == EXP_MAX) && (fb == '0);
    xa     = (ea == '0) ? EXP_W'(1) : ea;
    xb     = (eb == '0) ? EXP_W'(1) : eb;
    ma     = {ea != '0, fa};
    mb     = {eb != '0, fb};
    a_big  = {ea, fa} >= {eb, fb};
    c_spec = nan_a || nan_b || inf_a || inf_b;
    c_inv  = (nan_a && !fa[MAN_W-1]) || (nan_b && !fb[MAN_W-1]) || (inf_a && inf_b && (sa != sb));
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) c_spec_res = QNAN;
    else if (inf_a)                                         c_spec_res = bus.in_a;
    else                                                    c_spec_res = bus.in_b;
    c_sign = a_big ? sa : sb;
    c_exp  = a_big ? xa : xb;
    c_diff = a_big ? (xa - xb) : (xb - xa);
    c_ml   = {(a_big ? ma : mb), 3'b000};
    m_s    = a_big ? mb : ma;
    ext_s  = {m_s, 3'b000};
    sh_s   = ext_s >> c_diff;
    mask_s = ~({AW{1'b1}} << c_diff);
    if (int'(c_diff) >= MAN_W + 3) c_ms = {{(AW-1){1'b0}}, |m_s};
    else                           c_ms = {sh_s[AW-1:1], sh_s[0] | (|(ext_s & mask_s))};
  end

  logic             s1_sign, s1_sub, s1_spec, s1_inv;
  logic [EXP_W-1:0] s1_exp;
  logic [AW-1:0]    s1_ml, s1_ms;
  logic [1:0]       s1_rm;
  logic [TAG_W-1:0] s1_tag;
  logic [W-1:0]     s1_spec_res;

  logic             s2_sign, s2_sub, s2_spec, s2_inv;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_sum;
  logic [1:0]       s2_rm;
  logic [TAG_W-1:0] s2_tag;
  logic [W-1:0]     s2_spec_res;

  always_ff @(posedge clk) begin
    if (adv1 && bus.in_valid) begin
      s1_sign     <= c_sign;
      s1_sub      <= sa ^ sb;
      s1_spec     <= c_spec;
      s1_inv      <= c_inv;
      s1_spec_res <= c_spec_res;
      s1_exp      <= c_exp;
      s1_ml       <= c_ml;
      s1_ms       <= c_ms;
      s1_rm       <= bus.in_rm;
      s1_tag      <= bus.in_tag;
    end
    if (adv2 && v1) begin
      s2_sign     <= s1_sign;
      s2_sub      <= s1_sub;
      s2_spec     <= s1_spec;
      s2_inv      <= s1_inv;
      s2_spec_res <= s1_spec_res;
      s2_exp      <= s1_exp;
      s2_sum      <= s1_sub ? ({1'b0, s1_ml} - {1'b0, s1_ms}) : ({1'b0, s1_ml} + {1'b0, s1_ms});
      s2_rm       <= s1_rm;
      s2_tag      <= s1_tag;
    end
  end

  // S3 combinational: normalise (clamped at the subnormal exponent), round, pack
  int               lz, sh;
  logic [AW-1:0]    norm;
  logic [EXP_W:0]   e_n, e_r;
  logic [MAN_W+1:0] m_r;
  logic [MAN_W-1:0] frac;
  logic             inx, rup, tiny, to_max;
  logic [W-1:0]     res;
  logic [3:0]       flg;

  always_comb begin
    lz = SW - 1;
    for (int i = 0; i < SW - 1; i++) if (s2_sum[i]) lz = SW - 2 - i;
    sh = 0;
    if (s2_sum[SW-1]) begin
      norm = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
      e_n  = {1'b0, s2_exp} + 1'b1;
    end else begin
      sh   = (lz < int'(s2_exp) - 1) ? lz : int'(s2_exp) - 1;
      norm = AW'(s2_sum << sh);
      e_n  = {1'b0, s2_exp} - (EXP_W+1)'(sh);
    end
    tiny = !norm[AW-1];
    inx  = norm[2] | norm[1] | norm[0];
    case (s2_rm)
      RM_RNE:  rup = norm[2] && (norm[1] || norm[0] || norm[3]);
      RM_RDN:  rup = s2_sign && inx;
      RM_RUP:  rup = !s2_sign && inx;
      default: rup = 1'b0;
    endcase
    m_r = {1'b0, norm[AW-1:3]} + (MAN_W+2)'(rup);
    if (m_r[MAN_W+1]) begin
      e_r  = e_n + 1'b1;
      frac = '0;
    end else begin
      e_r  = m_r[MAN_W] ? e_n : '0;
      frac = m_r[MAN_W-1:0];
    end
    res    = {s2_sign, e_r[EXP_W-1:0], frac};
    flg    = {2'b00, tiny && inx, inx};
    to_max = (s2_rm == RM_RTZ) || (s2_rm == RM_RDN && !s2_sign) || (s2_rm == RM_RUP && s2_sign);
    if (s2_spec) begin
      res = s2_spec_res;
      flg = {s2_inv, 3'b000};
    end else if (s2_sum == '0) begin
      res = {(s2_sub ? (s2_rm == RM_RDN) : s2_sign), {(W-1){1'b0}}};
      flg = 4'b0000;
    end else if (e_r >= {1'b0, EXP_MAX}) begin
      res = to_max ? {s2_sign, EXP_MAX - 1'b1, {MAN_W{1'b1}}} : {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
      flg = 4'b0101;
    end
  end

  logic [W-1:0]     r_result;
  logic [TAG_W-1:0] r_tag;
  logic [3:0]       r_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      r_result <= '0;
      r_tag    <= '0;
      r_flags  <= '0;
    end else begin
      if (adv1) v1 <= bus.in_valid;
      if (adv2) v2 <= v1;
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          r_result <= res;
          r_tag    <= s2_tag;
          r_flags  <= flg;
        end
      end
    end
  end

  assign bus.out_valid  = v3;
  assign bus.out_result = r_result;
  assign bus.out_tag    = r_tag;
  assign bus.out_flags  = r_flags;
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed-vector bench for fp_add_pipe in single precision: arithmetic corner cases,
// latency, backpressure with in-order drain, and reset discarding in-flight ops.
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  fp_add_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();

  fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one op with out_ready high; result must show three edges after presentation.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic [3:0] tag,
                        input logic [31:0] exp_res, input logic [3:0] exp_flg);
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_rm     = rm;
    bus.in_tag    = tag;
    bus.out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, "/lat"}, lat, 3);
    check({name, "/res"}, bus.out_result, exp_res);
    check({name, "/flags"}, {28'd0, bus.out_flags}, {28'd0, exp_flg});
    check({name, "/tag"}, {28'd0, bus.out_tag}, {28'd0, tag});
  endtask

  logic [31:0] b_tab [8];
  logic [31:0] s_tab [8];
  int          sent, recv;
  logic        fire_in, fire_out;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_rm     = 2'b00;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    b_tab = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    s_tab = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
              32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/out_valid", {31'd0, bus.out_valid}, 0);
    check("rst/out_result", bus.out_result, 0);
    check("rst/out_tag_flags", {24'd0, bus.out_tag, bus.out_flags}, 0);
    rst = 1'b0;
    #1;
    check("rst/in_ready", {31'd0, bus.in_ready}, 1);

    run_op("one_plus_one",  32'h3F800000, 32'h3F800000, 2'b00, 4'h5, 32'h40000000, 4'b0000);
    run_op("half_ulp_rne",  32'h3F800000, 32'h33800000, 2'b00, 4'h1, 32'h3F800000, 4'b0001);
    run_op("half_ulp_rup",  32'h3F800000, 32'h33800000, 2'b11, 4'h2, 32'h3F800001, 4'b0001);
    run_op("half_ulp_rtz",  32'h3F800000, 32'h33800000, 2'b01, 4'h3, 32'h3F800000, 4'b0001);
    run_op("ovf_rne",       32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 4'h4, 32'h7F800000, 4'b0101);
    run_op("ovf_rtz",       32'h7F7FFFFF, 32'h7F7FFFFF, 2'b01, 4'h6, 32'h7F7FFFFF, 4'b0101);
    run_op("ovf_pos_rdn",   32'h7F7FFFFF, 32'h7F7FFFFF, 2'b10, 4'h7, 32'h7F7FFFFF, 4'b0101);
    run_op("ovf_neg_rup",   32'hFF7FFFFF, 32'hFF7FFFFF, 2'b11, 4'h8, 32'hFF7FFFFF, 4'b0101);
    run_op("ovf_neg_rdn",   32'hFF7FFFFF, 32'hFF7FFFFF, 2'b10, 4'h9, 32'hFF800000, 4'b0101);
    run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 2'b00, 4'hA, 32'h7FC00000, 4'b1000);
    run_op("snan_in",       32'h7F800001, 32'h3F800000, 2'b00, 4'hB, 32'h7FC00000, 4'b1000);
    run_op("qnan_in",       32'h3F800000, 32'h7FC00000, 2'b00, 4'hC, 32'h7FC00000, 4'b0000);
    run_op("neg_inf_fin",   32'hFF800000, 32'h3F800000, 2'b11, 4'hD, 32'hFF800000, 4'b0000);
    run_op("cancel_rne",    32'h3FC00000, 32'hBFC00000, 2'b00, 4'hE, 32'h00000000, 4'b0000);
    run_op("cancel_rdn",    32'h3FC00000, 32'hBFC00000, 2'b10, 4'hF, 32'h80000000, 4'b0000);
    run_op("neg_zeros",     32'h80000000, 32'h80000000, 2'b00, 4'h1, 32'h80000000, 4'b0000);
    run_op("sub_b_larger",  32'h3F800000, 32'hBFC00000, 2'b00, 4'h2, 32'hBF000000, 4'b0000);
    run_op("sub_to_norm",   32'h00400000, 32'h00400000, 2'b00, 4'h3, 32'h00800000, 4'b0000);
    run_op("norm_to_sub",   32'h00800001, 32'h80800000, 2'b00, 4'h4, 32'h00000001, 4'b0000);

    // 8 back-to-back ops, consumer stalled for the first 5 cycles
    sent = 0;
    recv = 0;
    for (int c = 0; c < 80 && recv < 8; c++) begin
      @(negedge clk);
      bus.out_ready = (c >= 5);
      bus.in_valid  = (sent < 8);
      bus.in_a      = 32'h3F800000;
      bus.in_b      = b_tab[sent % 8];
      bus.in_rm     = 2'b00;
      bus.in_tag    = 4'(sent);
      #1;
      if (c == 4) begin
        check("stall/accepted", sent, 3);
        check("stall/in_ready", {31'd0, bus.in_ready}, 0);
        check("stall/out_held", bus.out_result, s_tab[0]);
      end
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      if (fire_out) begin
        check($sformatf("stream%0d/tag", recv), {28'd0, bus.out_tag}, 32'(recv));
        check($sformatf("stream%0d/res", recv), bus.out_result, s_tab[recv % 8]);
        recv++;
      end
      @(posedge clk);
      if (fire_in) sent++;
    end
    check("stream/count", recv, 8);

    // Two ops in flight, then reset: neither may emerge
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_b      = 32'h40000000;
    bus.in_tag    = 4'h9;
    @(negedge clk);
    bus.in_tag    = 4'hA;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid/out_valid", {31'd0, bus.out_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_mid/quiet%0d", k), {31'd0, bus.out_valid}, 0);
    end
    check("rst_mid/out_result", bus.out_result, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
